// File: rtl/jt12_pkg.sv
// Shared definitions for the jt12 write decoder: register addresses, the
// strobe selector, FSM state encoding and register-decode helpers.
package jt12_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    UPD_NONE,
    UPD_KEYON,
    UPD_ALG,
    UPD_BLOCK,
    UPD_FNUMLO,
    UPD_PMS,
    UPD_DT1,
    UPD_TL,
    UPD_KS_AR,
    UPD_AMEN_D1R,
    UPD_D2R,
    UPD_D1L,
    UPD_SSGEG
  } upd_e;

  localparam logic [7:0] REG_MODE  = 8'h27;
  localparam logic [7:0] REG_KEYON = 8'h28;

  // Upper nibble of operator registers 0x30-0x9F selects the parameter.
  function automatic upd_e nibble_upd(input logic [3:0] nib);
    case (nib)
      4'h3:    return UPD_DT1;
      4'h4:    return UPD_TL;
      4'h5:    return UPD_KS_AR;
      4'h6:    return UPD_AMEN_D1R;
      4'h7:    return UPD_D2R;
      4'h8:    return UPD_D1L;
      4'h9:    return UPD_SSGEG;
      default: return UPD_NONE;
    endcase
  endfunction

  // Channel slot 3 (reg[1:0]=3) does not exist, and key-on to that slot is dropped.
  function automatic upd_e decode_upd(input logic part, input logic [7:0] r,
                                      input logic [1:0] keyon_lo);
    if (r == REG_KEYON)
      return (!part && keyon_lo != 2'd3) ? UPD_KEYON : UPD_NONE;
    if (r[1:0] == 2'd3)
      return UPD_NONE;
    case (r[7:2])
      6'b1010_00: return UPD_FNUMLO;
      6'b1010_01: return UPD_BLOCK;
      6'b1011_00: return UPD_ALG;
      6'b1011_01: return UPD_PMS;
      default:    return nibble_upd(r[7:4]);
    endcase
  endfunction

  function automatic logic is_ch3_lo(input logic [7:0] r);
    return r[7:2] == 6'b1010_10 && r[1:0] != 2'd3;
  endfunction

  function automatic logic is_ch3_hi(input logic [7:0] r);
    return r[7:2] == 6'b1010_11 && r[1:0] != 2'd3;
  endfunction

endpackage

// File: rtl/jt12_ch3fnum.sv
// CH3 special-mode frequency store: a shared block/fnum-high latch loaded by
// 0xAC-AE, committed together with fnum-low by 0xA8 (op3), 0xA9 (op1), 0xAA (op2).
module jt12_ch3fnum (
  input  logic        rst,
  input  logic        clk,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [1:0]  sel,
  input  logic [7:0]  din,
  output logic [10:0] fnum_ch3op1,
  output logic [10:0] fnum_ch3op2,
  output logic [10:0] fnum_ch3op3,
  output logic [2:0]  block_ch3op1,
  output logic [2:0]  block_ch3op2,
  output logic [2:0]  block_ch3op3
);

  logic [5:0] hi_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q         <= '0;
      fnum_ch3op1  <= '0;
      fnum_ch3op2  <= '0;
      fnum_ch3op3  <= '0;
      block_ch3op1 <= '0;
      block_ch3op2 <= '0;
      block_ch3op3 <= '0;
    end else begin
      if (we_hi) hi_q <= din[5:0];
      if (we_lo) begin
        case (sel)
          2'd0: begin fnum_ch3op3 <= {hi_q[2:0], din}; block_ch3op3 <= hi_q[5:3]; end
          2'd1: begin fnum_ch3op1 <= {hi_q[2:0], din}; block_ch3op1 <= hi_q[5:3]; end
          2'd2: begin fnum_ch3op2 <= {hi_q[2:0], din}; block_ch3op2 <= hi_q[5:3]; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/jt12_wrdec.sv
// jt12 CPU write decoder: turns address/data writes into one update strobe
// held until the register bank finishes. CH3 special mode needs JT12_CH3_EFFECT_EN.
module jt12_wrdec
  import jt12_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        clk_en,
  input  logic [7:0]  cpu_din,
  input  logic [1:0]  addr,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        busy_in,
  output logic [7:0]  din,
  output logic [2:0]  ch,
  output logic [1:0]  op,
  output logic        up_keyon,
  output logic        up_alg,
  output logic        up_block,
  output logic        up_fnumlo,
  output logic        up_pms,
  output logic        up_dt1,
  output logic        up_tl,
  output logic        up_ks_ar,
  output logic        up_amen_d1r,
  output logic        up_d2r,
  output logic        up_d1l,
  output logic        up_ssgeg,
  output logic        effect,
  output logic        csm,
  output logic [10:0] fnum_ch3op1,
  output logic [10:0] fnum_ch3op2,
  output logic [10:0] fnum_ch3op3,
  output logic [2:0]  block_ch3op1,
  output logic [2:0]  block_ch3op2,
  output logic [2:0]  block_ch3op3,
  output logic        busy
);

  state_e     state, state_nxt;
  upd_e       upd_q, upd_nxt;
  logic [8:0] sel_reg;
  logic       cpu_wr, addr_wr, data_wr, start, mode_wr;

  assign cpu_wr  = ~cs_n & ~wr_n;
  assign addr_wr = cpu_wr & ~addr[0];
  // Data writes are only taken in IDLE, which also drops one landing as HOLD exits.
  assign data_wr = cpu_wr & addr[0] & (state == ST_IDLE);
  assign upd_nxt = decode_upd(sel_reg[8], sel_reg[7:0], cpu_din[1:0]);
  assign start   = data_wr & (upd_nxt != UPD_NONE);
  assign mode_wr = data_wr & (sel_reg == {1'b0, REG_MODE});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sel_reg <= '0;
    else if (addr_wr) sel_reg <= {addr[1], cpu_din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // busy_in is only meaningful on slot-advance cycles of the register bank.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)              state_nxt = ST_ARM;
      ST_ARM:  if (clk_en && busy_in)  state_nxt = ST_HOLD;
      ST_HOLD: if (clk_en && !busy_in) state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: datapath latches are reset too, so din/ch/op read 0 out of reset
  // instead of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q <= UPD_NONE;
      din   <= '0;
      ch    <= '0;
      op    <= '0;
    end else if (data_wr) begin
      upd_q <= upd_nxt;
      din   <= cpu_din;
      ch    <= (upd_nxt == UPD_KEYON) ? cpu_din[2:0] : {sel_reg[8], sel_reg[1:0]};
      op    <= sel_reg[3:2];
    end
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    busy        = (state != ST_IDLE);
    up_keyon    = 1'b0;
    up_alg      = 1'b0;
    up_block    = 1'b0;
    up_fnumlo   = 1'b0;
    up_pms      = 1'b0;
    up_dt1      = 1'b0;
    up_tl       = 1'b0;
    up_ks_ar    = 1'b0;
    up_amen_d1r = 1'b0;
    up_d2r      = 1'b0;
    up_d1l      = 1'b0;
    up_ssgeg    = 1'b0;
    if (state != ST_IDLE) begin
      case (upd_q)
        UPD_KEYON:    up_keyon    = 1'b1;
        UPD_ALG:      up_alg      = 1'b1;
        UPD_BLOCK:    up_block    = 1'b1;
        UPD_FNUMLO:   up_fnumlo   = 1'b1;
        UPD_PMS:      up_pms      = 1'b1;
        UPD_DT1:      up_dt1      = 1'b1;
        UPD_TL:       up_tl       = 1'b1;
        UPD_KS_AR:    up_ks_ar    = 1'b1;
        UPD_AMEN_D1R: up_amen_d1r = 1'b1;
        UPD_D2R:      up_d2r      = 1'b1;
        UPD_D1L:      up_d1l      = 1'b1;
        UPD_SSGEG:    up_ssgeg    = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef JT12_CH3_EFFECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csm    <= 1'b0;
      effect <= 1'b0;
    end else if (mode_wr) begin
      csm    <= cpu_din[7];
      effect <= cpu_din[6];
    end
  end

  jt12_ch3fnum u_ch3fnum (
    .rst          (rst),
    .clk          (clk),
    .we_hi        (data_wr & ~sel_reg[8] & is_ch3_hi(sel_reg[7:0])),
    .we_lo        (data_wr & ~sel_reg[8] & is_ch3_lo(sel_reg[7:0])),
    .sel          (sel_reg[1:0]),
    .din          (cpu_din),
    .fnum_ch3op1  (fnum_ch3op1),
    .fnum_ch3op2  (fnum_ch3op2),
    .fnum_ch3op3  (fnum_ch3op3),
    .block_ch3op1 (block_ch3op1),
    .block_ch3op2 (block_ch3op2),
    .block_ch3op3 (block_ch3op3)
  );
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          csm <= 1'b0;
    else if (mode_wr) csm <= cpu_din[7];
  end

  assign effect       = 1'b0;
  assign fnum_ch3op1  = '0;
  assign fnum_ch3op2  = '0;
  assign fnum_ch3op3  = '0;
  assign block_ch3op1 = '0;
  assign block_ch3op2 = '0;
  assign block_ch3op3 = '0;
`endif

endmodule

// File: tb/tb_jt12_wrdec.sv
// Directed self-checking bench for jt12_wrdec; CH3 expectations follow
// whether JT12_CH3_EFFECT_EN is defined for the build.
module tb_jt12_wrdec;

  logic        rst, clk, clk_en, cs_n, wr_n, busy_in;
  logic [7:0]  cpu_din;
  logic [1:0]  addr;
  logic [7:0]  din;
  logic [2:0]  ch;
  logic [1:0]  op;
  logic        up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1, up_tl;
  logic        up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg;
  logic        effect, csm, busy;
  logic [10:0] fnum_ch3op1, fnum_ch3op2, fnum_ch3op3;
  logic [2:0]  block_ch3op1, block_ch3op2, block_ch3op3;
  logic [11:0] ups;

  int n_tests = 0;
  int n_fail  = 0;

  jt12_wrdec dut (
    .rst(rst), .clk(clk), .clk_en(clk_en), .cpu_din(cpu_din), .addr(addr),
    .cs_n(cs_n), .wr_n(wr_n), .busy_in(busy_in), .din(din), .ch(ch), .op(op),
    .up_keyon(up_keyon), .up_alg(up_alg), .up_block(up_block), .up_fnumlo(up_fnumlo),
    .up_pms(up_pms), .up_dt1(up_dt1), .up_tl(up_tl), .up_ks_ar(up_ks_ar),
    .up_amen_d1r(up_amen_d1r), .up_d2r(up_d2r), .up_d1l(up_d1l), .up_ssgeg(up_ssgeg),
    .effect(effect), .csm(csm),
    .fnum_ch3op1(fnum_ch3op1), .fnum_ch3op2(fnum_ch3op2), .fnum_ch3op3(fnum_ch3op3),
    .block_ch3op1(block_ch3op1), .block_ch3op2(block_ch3op2), .block_ch3op3(block_ch3op3),
    .busy(busy)
  );

  // Strobe vector, MSB first: keyon alg block fnumlo pms dt1 tl ks_ar amen_d1r d2r d1l ssgeg
  assign ups = {up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1, up_tl,
                up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg};

  localparam logic [11:0] S_KEYON = 12'h800, S_ALG = 12'h400, S_BLOCK = 12'h200;
  localparam logic [11:0] S_TL = 12'h020, S_KS_AR = 12'h010, S_SSGEG = 12'h001;

`ifdef JT12_CH3_EFFECT_EN
  localparam bit CH3_ON = 1'b1;
`else
  localparam bit CH3_ON = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle CPU write, sampled at the posedge between two falling edges.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; cpu_din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic reg_write(input logic part, input logic [7:0] r, input logic [7:0] d);
    cpu_write({part, 1'b0}, r);
    cpu_write({part, 1'b1}, d);
  endtask

  // Register bank raises busy_in for n cycles, then the decoder returns to IDLE.
  task automatic bank_ack(input int n);
    @(negedge clk);
    busy_in = 1'b1;
    repeat (n) @(negedge clk);
    busy_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; cs_n = 1'b1; wr_n = 1'b1;
    busy_in = 1'b0; cpu_din = '0; addr = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_ups", ups, 0);
    check("rst_din_ch_op", {din, ch, op}, 0);
    check("rst_mode", {effect, csm}, 0);
    check("rst_ch3", {fnum_ch3op1, block_ch3op1, fnum_ch3op3, block_ch3op3}, 0);
    rst = 1'b0;
    @(negedge clk);

    // TL write, channel 2 slot S1, held through ARM and HOLD
    reg_write(1'b0, 8'h42, 8'h7F);
    check("tl_arm_ups", ups, S_TL);
    check("tl_arm_busy", busy, 1);
    check("tl_arm_data", {din, 5'(ch), 6'(op)}, {8'h7F, 5'd2, 6'd0});
    @(negedge clk);
    busy_in = 1'b1;
    @(negedge clk);
    check("tl_hold_ups", ups, S_TL);
    // second data write during HOLD is dropped
    cpu_write(2'b01, 8'h11);
    check("hold_write_din", din, 8'h7F);
    check("hold_write_ups", ups, S_TL);
    // data write landing in the exit cycle is dropped as well
    @(negedge clk);
    busy_in = 1'b0; cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; cpu_din = 8'h22;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    check("tl_done_busy", busy, 0);
    check("tl_done_ups", ups, 0);
    check("exit_write_din", din, 8'h7F);
    @(negedge clk);
    check("exit_write_idle", busy, 0);

    // key-on with a 24-cycle busy pulse
    reg_write(1'b0, 8'h28, 8'hF5);
    check("keyon_ups", ups, S_KEYON);
    check("keyon_din_ch", {din, 5'(ch)}, {8'hF5, 5'd5});
    @(negedge clk);
    busy_in = 1'b1;
    repeat (12) @(negedge clk);
    check("keyon_mid_busy", {4'(busy), ups}, {4'd1, S_KEYON});
    repeat (12) @(negedge clk);
    check("keyon_end_busy", busy, 1);
    busy_in = 1'b0;
    @(negedge clk);
    check("keyon_idle", {4'(busy), ups}, 16'h0);

    // key-on to channel slot 3 and operator slot reg[1:0]=3 are ignored
    reg_write(1'b0, 8'h28, 8'hF3);
    check("keyon3_ign", {4'(busy), ups}, 16'h0);
    reg_write(1'b0, 8'h33, 8'h12);
    check("reg33_ign", {4'(busy), ups}, 16'h0);
    reg_write(1'b1, 8'h28, 8'hF1);
    check("keyon_p2_ign", {4'(busy), ups}, 16'h0);

    // part II algorithm; address write accepted while busy
    reg_write(1'b1, 8'hB1, 8'h07);
    check("alg_ups", ups, S_ALG);
    check("alg_ch_op", {5'(ch), 6'(op)}, {5'd5, 6'd0});
    cpu_write(2'b00, 8'hA5);
    bank_ack(3);
    check("alg_idle", busy, 0);
    cpu_write(2'b01, 8'h21);
    check("block_ups", ups, S_BLOCK);
    check("block_ch_op", {din, 5'(ch), 6'(op)}, {8'h21, 5'd1, 6'd1});
    bank_ack(2);

    // upper boundary of the operator range
    reg_write(1'b0, 8'h9E, 8'h0A);
    check("ssgeg_ups", ups, S_SSGEG);
    check("ssgeg_ch_op", {5'(ch), 6'(op)}, {5'd2, 6'd3});
    bank_ack(1);

    // mode register: local, no busy
    reg_write(1'b0, 8'h27, 8'hC0);
    check("mode_busy", {4'(busy), ups}, 16'h0);
    check("mode_bits", {effect, csm}, {CH3_ON, 1'b1});

    // CH3 special-mode fnum commit
    reg_write(1'b0, 8'hAD, 8'h2A);
    check("ch3_hi_busy", busy, 0);
    reg_write(1'b0, 8'hA9, 8'h55);
    check("ch3_op1", {5'(block_ch3op1), fnum_ch3op1},
          CH3_ON ? {5'd5, 11'h255} : 16'h0);
    check("ch3_op3_untouched", {block_ch3op3, fnum_ch3op3}, 0);
    reg_write(1'b1, 8'hA9, 8'hFF);
    check("ch3_p2_ign", {5'(block_ch3op1), fnum_ch3op1},
          CH3_ON ? {5'd5, 11'h255} : 16'h0);
    check("ch3_p2_busy", {4'(busy), ups}, 16'h0);

    // reset in ARM aborts at once, next write is normal
    reg_write(1'b0, 8'h42, 8'h33);
    check("pre_rst_arm", ups, S_TL);
    #2 rst = 1'b1;
    #1;
    check("rst_arm_ups", {4'(busy), ups}, 16'h0);
    check("rst_arm_mode", csm, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {4'(busy), ups}, 16'h0);
    reg_write(1'b0, 8'h50, 8'h1F);
    check("post_rst_ksar", ups, S_KS_AR);
    check("post_rst_data", {din, 5'(ch), 6'(op)}, {8'h1F, 5'd0, 6'd0});
    bank_ack(2);
    check("post_rst_done", {4'(busy), ups}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jt12_wrdec.md
JT12_WRDEC -- requirements
Module: jt12_wrdec

Interface
REQ-001 SHALL have these ports, clock and reset first:
- rst  in  1  reset; asynchronous, active-high.
- clk  in  1  sole clock.
- clk_en  in  1  slot-advance enable, shared with the register bank.
- cpu_din  in  8  CPU write data.
- addr  in  2  addr[0]: 0 = address write, 1 = data write; addr[1]: part (0 = ch0-2, 1 = ch4-6).
- cs_n, wr_n  in  1 each  CPU strobes; a write is cs_n=0 & wr_n=0, sampled on clk.
- busy_in  in  1  busy flag from the register bank.
- din  out  8  latched data to the register bank.
- ch  out  3  target channel {part, reg[1:0]}.
- op  out  2  target slot = reg[3:2] (0=S1, 1=S3, 2=S2, 3=S4).
- up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1, up_tl, up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg  out  1 each  update strobes.
- effect, csm  out  1 each  from reg 0x27 bits [6], [7].
- fnum_ch3op1/op2/op3  out  11 each  CH3 special-mode fnums.
- block_ch3op1/op2/op3  out  3 each  CH3 special-mode blocks.
- busy  out  1  write in progress (CPU-readable).

Function
REQ-002 An address write SHALL latch {addr[1], cpu_din} into the selected-register latch in 1 cycle, in any FSM state.
REQ-003 A data write in IDLE SHALL latch cpu_din to din and decode the selected register.
- 0x30-0x9F: ch/op per REQ-001; upper nibble 3..9 selects dt1, tl, ks_ar, amen_d1r, d2r, d1l, ssgeg.
- 0xA0-A2 fnumlo, 0xA4-A6 block, 0xB0-B2 alg, 0xB4-B6 pms.
- 0x28 keyon, part I only; ch = cpu_din[2:0].
REQ-004 A data write with reg[1:0]=3, or keyon with din[1:0]=3, SHALL be ignored: no strobe, stays IDLE.
REQ-005 The FSM SHALL have three states:
- IDLE: on a valid write, assert exactly one up_* strobe and go to ARM.
- ARM: when busy_in=1, go to HOLD.
- HOLD: when busy_in=0, drop the strobe and go to IDLE.
REQ-006 up_*, din, ch and op SHALL be held stable from ARM entry until return to IDLE.
REQ-007 busy SHALL be 1 in ARM and HOLD, and SHALL go high the cycle after the data write.
REQ-008 Data writes while busy=1 SHALL be discarded; address writes are still accepted.
REQ-009 Writes to 0x27, 0xA8-AA and 0xAC-AE SHALL be completed locally in 1 cycle, with no strobe and no busy.
REQ-010 0xAC/0xAD/0xAE SHALL load a pending block/fnhi latch.
REQ-011 The next write to 0xA8/0xA9/0xAA SHALL commit {latch, fnlo} to op3/op1/op2 respectively.
REQ-012 Part-II writes in 0xA8-AE and 0x27 SHALL be ignored.
REQ-013 A write sampled in the same cycle that HOLD exits SHALL be discarded.

Reset
REQ-014 While rst=1, all of the following SHALL be 0:
- the FSM, held in IDLE;
- busy, all up_*, din, ch, op;
- effect, csm;
- all ch3 fnum/block outputs and latches;
- the register latch.
REQ-015 Reset asserted in ARM or HOLD SHALL abort the write immediately, with no strobe glitch on release.

Configuration
REQ-016 With JT12_CH3_EFFECT_EN defined, REQ-009 to REQ-011 SHALL apply.
REQ-017 Without JT12_CH3_EFFECT_EN:
- effect and all fnum_ch3*/block_ch3* outputs SHALL be tied to 0;
- 0xA8-AE SHALL be ignored;
- 0x27 SHALL update csm only.

Structure
REQ-018 Register address constants, the nibble-to-strobe map and the FSM state encoding SHALL live in the shared package jt12_pkg.
REQ-019 The CH3 latch/commit store SHALL be the sub-module jt12_ch3fnum.

Verification
REQ-020 Address 0x42 on part 0, data 0x7F -> up_tl=1, ch=2, op=0, din=0x7F until busy_in falls.
REQ-021 Address 0x28, data 0xF5 -> up_keyon=1, din=0xF5; busy held through a 24-slot busy_in pulse, then IDLE.
REQ-022 Address 0x33, then data -> no strobe, busy stays 0.
REQ-023 Second data write during HOLD -> ignored; din retains the first value.
REQ-024 Data 0x2A to 0xAD, then 0x55 to 0xA9 -> block_ch3op1=5, fnum_ch3op1=0x255; without the macro, both stay 0.
REQ-025 rst pulse while in ARM -> all strobes and busy 0 within the same cycle; the next write proceeds normally.
